// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit (FETCH/DCD/EXE/MEM/WB/HALT).
// Walks each instruction through its states and drives the IFU, GPR file,
// ALU, extender and data-memory controls. Outputs are combinational from the
// current state and the instruction register, gated off while rst is low.
// Optional feature macro: MC_CTRL_OVF_EN (add/addi with overflow trap).
`timescale 1ns/1ps

module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ack,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] npc_sel,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       illegal,
    output logic       ovf_trap,
    output logic [2:0] state
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 3;

    // Opcode / funct encodings
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
`ifdef MC_CTRL_OVF_EN
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
`endif
    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    // ALU / extender / mux select encodings
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b011;
    localparam logic [ALU_W-1:0] ALU_LUI = 3'b100;

    localparam logic [SEL_W-1:0] EXT_ZERO  = 2'b00;
    localparam logic [SEL_W-1:0] EXT_SIGN  = 2'b01;
    localparam logic [SEL_W-1:0] EXT_UPPER = 2'b10;

    localparam logic [SEL_W-1:0] NPC_PC4    = 2'b00;
    localparam logic [SEL_W-1:0] NPC_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] NPC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] NPC_JR     = 2'b11;

    localparam logic [SEL_W-1:0] DST_RT = 2'b00;
    localparam logic [SEL_W-1:0] DST_RD = 2'b01;
    localparam logic [SEL_W-1:0] DST_RA = 2'b10;

    localparam logic [SEL_W-1:0] WD_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WD_MEM = 2'b01;
    localparam logic [SEL_W-1:0] WD_PC  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd7
    } state_e;

    state_e state_q, state_d;
    logic   ovf_q, ovf_d;
    logic   illegal_q, illegal_d;

    // Decoded instruction class and datapath selects
    logic             dec_legal;
    logic             dec_alu;
    logic             dec_rtype;
    logic             dec_lw;
    logic             dec_sw;
    logic             dec_beq;
    logic             dec_j;
    logic             dec_jal;
    logic             dec_jr;
    logic             dec_ovf_chk;
    logic [ALU_W-1:0] dec_alu_op;
    logic             dec_alu_src;
    logic [SEL_W-1:0] dec_ext_op;

    // Instruction decode from the IR fields (stable from DCD to next FETCH)
    always_comb begin
        dec_legal   = 1'b0;
        dec_alu     = 1'b0;
        dec_rtype   = 1'b0;
        dec_lw      = 1'b0;
        dec_sw      = 1'b0;
        dec_beq     = 1'b0;
        dec_j       = 1'b0;
        dec_jal     = 1'b0;
        dec_jr      = 1'b0;
        dec_ovf_chk = 1'b0;
        dec_alu_op  = ALU_ADD;
        dec_alu_src = 1'b0;
        dec_ext_op  = EXT_ZERO;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin
                        dec_legal = 1'b1;
                        dec_alu   = 1'b1;
                        dec_rtype = 1'b1;
                    end
                    FN_SUBU: begin
                        dec_legal  = 1'b1;
                        dec_alu    = 1'b1;
                        dec_rtype  = 1'b1;
                        dec_alu_op = ALU_SUB;
                    end
                    FN_SLT: begin
                        dec_legal  = 1'b1;
                        dec_alu    = 1'b1;
                        dec_rtype  = 1'b1;
                        dec_alu_op = ALU_SLT;
                    end
                    FN_JR: begin
                        dec_legal = 1'b1;
                        dec_jr    = 1'b1;
                    end
`ifdef MC_CTRL_OVF_EN
                    FN_ADD: begin
                        dec_legal   = 1'b1;
                        dec_alu     = 1'b1;
                        dec_rtype   = 1'b1;
                        dec_ovf_chk = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec_legal   = 1'b1;
                dec_alu     = 1'b1;
                dec_alu_op  = ALU_OR;
                dec_alu_src = 1'b1;
                dec_ext_op  = EXT_ZERO;
            end
            OP_LUI: begin
                dec_legal   = 1'b1;
                dec_alu     = 1'b1;
                dec_alu_op  = ALU_LUI;
                dec_alu_src = 1'b1;
                dec_ext_op  = EXT_UPPER;
            end
`ifdef MC_CTRL_OVF_EN
            OP_ADDI: begin
                dec_legal   = 1'b1;
                dec_alu     = 1'b1;
                dec_ovf_chk = 1'b1;
                dec_alu_src = 1'b1;
                dec_ext_op  = EXT_SIGN;
            end
`endif
            OP_LW: begin
                dec_legal   = 1'b1;
                dec_lw      = 1'b1;
                dec_alu_src = 1'b1;
                dec_ext_op  = EXT_SIGN;
            end
            OP_SW: begin
                dec_legal   = 1'b1;
                dec_sw      = 1'b1;
                dec_alu_src = 1'b1;
                dec_ext_op  = EXT_SIGN;
            end
            OP_BEQ: begin
                dec_legal  = 1'b1;
                dec_beq    = 1'b1;
                dec_alu_op = ALU_SUB;
            end
            OP_J: begin
                dec_legal = 1'b1;
                dec_j     = 1'b1;
            end
            OP_JAL: begin
                dec_legal = 1'b1;
                dec_jal   = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic plus the overflow and illegal flag updates
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD:   state_d = dec_legal ? S_EXE : S_HALT;
            S_EXE: begin
                if (dec_ovf_chk) begin
                    ovf_d = overflow;
                end
                if (dec_lw || dec_sw) begin
                    state_d = S_MEM;
                end else if (dec_alu) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = dec_lw ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_HALT);
    end

    // State and flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    // Output decode per state; enables are forced low while reset is held
    always_comb begin
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        reg_wr   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        npc_sel  = NPC_PC4;
        alu_op   = ALU_ADD;
        alu_src  = 1'b0;
        ext_op   = EXT_ZERO;
        reg_dst  = DST_RT;
        wd_sel   = WD_ALU;
        ovf_trap = 1'b0;
        illegal  = illegal_q;
        case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                npc_sel = NPC_PC4;
            end
            S_EXE: begin
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                ext_op  = dec_ext_op;
                if (dec_beq) begin
                    pc_wr   = zero;
                    npc_sel = NPC_BRANCH;
                end
                if (dec_j || dec_jal) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_JUMP;
                end
                if (dec_jal) begin
                    reg_wr  = 1'b1;
                    reg_dst = DST_RA;
                    wd_sel  = WD_PC;
                end
                if (dec_jr) begin
                    pc_wr   = 1'b1;
                    npc_sel = NPC_JR;
                end
            end
            S_MEM: begin
                // ALU selects held so the address stays stable during the wait
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                ext_op  = dec_ext_op;
                mem_req = 1'b1;
                mem_we  = dec_sw;
            end
            S_WB: begin
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                ext_op  = dec_ext_op;
                reg_wr  = ~(dec_ovf_chk & ovf_q);
                reg_dst = dec_rtype ? DST_RD : DST_RT;
                wd_sel  = dec_lw ? WD_MEM : WD_ALU;
`ifdef MC_CTRL_OVF_EN
                ovf_trap = dec_ovf_chk & ovf_q;
`endif
            end
            default: ;
        endcase
        if (!rst) begin
            pc_wr    = 1'b0;
            ir_wr    = 1'b0;
            reg_wr   = 1'b0;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            ovf_trap = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath: a Moore/Mealy FSM that walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the write enables and mux selects of the IFU, GPR file, ALU, extender and data memory, and handshakes with a data memory that may take several cycles. It replaces single-cycle combinational control inside `mips` and reads `op`/`funct` from the datapath's instruction register.

## Interface
Parameters:
- none; encodings below are fixed.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `overflow`  in  1  ALU signed overflow flag.
- `mem_ack`  in  1  data memory done, sampled only in MEM.
- `pc_wr`  out  1  PC load enable.
- `ir_wr`  out  1  IR load enable.
- `reg_wr`  out  1  GPR write enable.
- `mem_req`  out  1  data memory request.
- `mem_we`  out  1  data memory write (valid with `mem_req`).
- `npc_sel`  out  2  00 pc+4, 01 branch, 10 jump, 11 jr.
- `alu_op`  out  3  000 ADD, 001 SUB, 010 OR, 011 SLT, 100 LUI.
- `alu_src`  out  1  0 rt, 1 extended immediate.
- `ext_op`  out  2  00 zero, 01 sign, 10 upper.
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31.
- `wd_sel`  out  2  00 ALU, 01 memory, 10 PC (link).
- `illegal`  out  1  sticky; high in HALT.
- `ovf_trap`  out  1  one-cycle pulse (see Configuration).
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4, HALT=7.
- FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=00. Next state DCD.
- DCD: no enables. Decode `op`/`funct`. Unsupported encoding -> HALT. Otherwise -> EXE.
- EXE, by class:
  - R-type addu(100001)/subu(100011)/slt(101010): `alu_src`=0, `alu_op` ADD/SUB/SLT. -> WB.
  - ori(001101): ext zero, OR. lui(001111): ext upper, LUI. Both -> WB.
  - lw(100011)/sw(101011): ext sign, ADD, `alu_src`=1. -> MEM.
  - beq(000100): SUB, `alu_src`=0. `pc_wr`=`zero`, `npc_sel`=01. -> FETCH.
  - j(000010): `pc_wr`=1, `npc_sel`=10. -> FETCH.
  - jal(000011): same as j, plus `reg_wr`=1, `reg_dst`=10, `wd_sel`=10 (PC already holds pc+4). -> FETCH.
  - jr (R-type, funct 001000): `pc_wr`=1, `npc_sel`=11. -> FETCH.
- MEM: `mem_req`=1, `mem_we`=1 for sw. ALU selects are held so the address stays stable.
  - Stay in MEM while `mem_ack`=0.
  - On `mem_ack`=1: sw -> FETCH, lw -> WB.
- WB: `reg_wr`=1.
  - `reg_dst`: 01 for R-type, 00 otherwise.
  - `wd_sel`: 01 for lw, 00 otherwise.
  - Selects from EXE are held. -> FETCH.
- HALT: all enables 0, `illegal`=1. Left only by reset.
- Every output not listed for a state is 0.

## Timing
- Outputs are combinational from `state` and the decoded IR. The IR is stable from DCD until the next FETCH.
- Reset: sampled at a rising edge with `rst`=0.
  - Next state FETCH; `illegal`=0, internal overflow flag=0.
  - While `rst`=0, all enables, `mem_req`, `ovf_trap` and `illegal` are forced to 0.
  - Reset mid-MEM drops `mem_req` in the same cycle; a late `mem_ack` is ignored.
- CPI:
  - beq, j, jal, jr: 3.
  - R-type, ori, lui: 4.
  - sw: 4 + wait cycles.
  - lw: 5 + wait cycles.
- `mem_ack` present in the first MEM cycle means zero wait cycles. `mem_ack` outside MEM is ignored.

## Configuration
- `MC_CTRL_OVF_EN` defined:
  - add (funct 100000) decodes as R-type ADD; addi (op 001000) as sign-extended immediate ADD.
  - `overflow` is registered at the end of EXE for these two instructions.
  - In WB, `reg_wr` = NOT registered overflow, and `ovf_trap` pulses for that one cycle when it is set. Execution continues.
- `MC_CTRL_OVF_EN` undefined:
  - add and addi are unsupported -> HALT.
  - `ovf_trap` is tied to 0.

## Test plan
- Reset, then addu $3,$1,$2 with $1=5, $2=7:
  - `state` sequence 0,1,2,4,0.
  - `reg_wr`=1 only in WB with `reg_dst`=01; $3=12.
- lw with `mem_ack` delayed 3 cycles:
  - `mem_req` high 4 cycles, then WB with `wd_sel`=01.
  - Total 8 cycles; PC advanced by 4 exactly once.
- beq with equal operands -> `pc_wr`=1, `npc_sel`=01 in EXE. With unequal operands -> `pc_wr`=0.
  - Both take 3 cycles.
- jal at PC 0x3000 -> $31=0x3004, `npc_sel`=10, back in FETCH after 3 cycles.
- Opcode 0x3F -> HALT on the cycle after DCD; `illegal`=1 and no enables until `rst`=0.
- With `MC_CTRL_OVF_EN`, addi 0x7FFFFFFF+1:
  - `ovf_trap`=1 for one WB cycle, `reg_wr`=0, destination unchanged.
  - Reset asserted mid-MEM of a later sw: `mem_req`=0 that cycle, then FETCH.
